// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and the multiply-by-ten step for the
// sequential BCD-to-binary converter.
package bcd_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;
    // Widest accumulator the shift-add helper handles; callers cast down.
    localparam int ACC_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // acc*10 + digit built from shifts: (acc<<3) + (acc<<1) + digit.
    function automatic logic [ACC_MAX_W-1:0] mul10_add(
        input logic [ACC_MAX_W-1:0] acc,
        input logic [DIGIT_W-1:0]   digit
    );
        return (acc << 3) + (acc << 1) + {{(ACC_MAX_W-DIGIT_W){1'b0}}, digit};
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Valid/ready operand and result bus of the BCD-to-binary converter.
// slave = converter side, master = producer/consumer side.
interface bcd2bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin;
    logic                  err;

    modport slave (
        input  in_valid, bcd, out_ready,
        output in_ready, out_valid, bin, err
    );

    modport master (
        output in_valid, bcd, out_ready,
        input  in_ready, out_valid, bin, err
    );
endinterface

// File: rtl/bcd2bin_mac.sv
// One conversion step: acc*10 + digit wrapped to BIN_W bits, plus a flag for
// a non-decimal digit. Flag logic only exists when BCD2BIN_ERR_EN is defined.
module bcd2bin_mac
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0]   i_acc,
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [BIN_W-1:0]   o_acc,
    output logic               o_bad
);

    // Raw digit value enters the sum even when it is above 9.
    assign o_acc = BIN_W'(mul10_add(ACC_MAX_W'(i_acc), i_digit));

`ifdef BCD2BIN_ERR_EN
    assign o_bad = (i_digit > DIGIT_W'(MAX_DIGIT));
`else
    assign o_bad = 1'b0;
`endif

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: consumes one digit per cycle, most
// significant first, and presents the result over a valid/ready handshake.
// Optional non-decimal digit check enabled with macro BCD2BIN_ERR_EN.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic          clk,
    input  logic          rst,
    bcd2bin_seq_if.slave  bus
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                     r_state;
    state_t                     w_next;
    logic [DIGIT_W*DIGITS-1:0]  r_sh;
    logic [BIN_W-1:0]           r_acc;
    logic [BIN_W-1:0]           w_acc_nx;
    logic [CNT_W-1:0]           r_cnt;
    logic                       w_bad;
    logic                       w_accept;
    logic                       w_last;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_last   = (r_cnt == CNT_W'(DIGITS - 1));

    bcd2bin_mac #(.BIN_W(BIN_W)) u_mac (
        .i_acc   (r_acc),
        .i_digit (r_sh[DIGIT_W*DIGITS-1 -: DIGIT_W]),
        .o_acc   (w_acc_nx),
        .o_bad   (w_bad)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: accept in IDLE, leave CONV on the last digit, leave DONE on handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_next = CONV;
            CONV:    if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    // in_ready is masked by rst so an operand offered during reset is never taken.
    assign bus.in_ready  = (r_state == IDLE) & ~rst;
    assign bus.out_valid = (r_state == DONE);
    assign bus.bin       = r_acc;

    // Operand shift register, accumulator and digit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sh  <= bus.bcd;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == CONV) begin
            r_sh  <= r_sh << DIGIT_W;
            r_acc <= w_acc_nx;
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef BCD2BIN_ERR_EN
    logic r_err;

    // Sticky non-decimal flag for the operand in flight, cleared on accept.
    always_ff @(posedge clk) begin
        if (rst)                              r_err <= 1'b0;
        else if (w_accept)                    r_err <= 1'b0;
        else if ((r_state == CONV) && w_bad)  r_err <= 1'b1;
    end

    assign bus.err = r_err;
`else
    logic w_unused_bad;
    assign w_unused_bad = w_bad;
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: directed cases followed by random operands, checked
// against a decimal-arithmetic reference. A 4-digit and a 5-digit instance
// share clock and reset.
module tb_bcd2bin_seq;

`ifdef BCD2BIN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   gap     = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used to measure accept-to-accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    bcd2bin_seq_if #(.DIGITS(4), .BIN_W(14)) if4 ();
    bcd2bin_seq_if #(.DIGITS(5), .BIN_W(17)) if5 ();

    bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    bcd2bin_seq #(.DIGITS(5), .BIN_W(17)) dut5 (.clk(clk), .rst(rst), .bus(if5));

    // Reference: decimal value of the digits (raw values, MSD first) mod 2^binw.
    function automatic logic [31:0] ref_bin(input logic [19:0] b, input int digits, input int binw);
        longint v = 0;
        for (int i = digits - 1; i >= 0; i--)
            v = v * 10 + longint'((b >> (4 * i)) & 20'hF);
        return 32'(v % (longint'(1) << binw));
    endfunction

    function automatic logic [31:0] ref_err(input logic [19:0] b, input int digits);
        bit e = 1'b0;
        for (int i = 0; i < digits; i++)
            if (((b >> (4 * i)) & 20'hF) > 9) e = 1'b1;
        return {31'd0, ERR_EN && e};
    endfunction

    function automatic logic [31:0] rd_valid(input int w);
        return {31'd0, (w == 5) ? if5.out_valid : if4.out_valid};
    endfunction

    function automatic logic [31:0] rd_ready(input int w);
        return {31'd0, (w == 5) ? if5.in_ready : if4.in_ready};
    endfunction

    function automatic logic [31:0] rd_bin(input int w);
        return (w == 5) ? {15'd0, if5.bin} : {18'd0, if4.bin};
    endfunction

    function automatic logic [31:0] rd_err(input int w);
        return {31'd0, (w == 5) ? if5.err : if4.err};
    endfunction

    task automatic set_in(input int w, input logic v, input logic [19:0] b);
        if (w == 5) begin
            if5.in_valid = v;
            if5.bcd      = b;
        end else begin
            if4.in_valid = v;
            if4.bcd      = b[15:0];
        end
    endtask

    task automatic set_ordy(input int w, input logic r);
        if (w == 5) if5.out_ready = r;
        else        if4.out_ready = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full transaction: accept, measure latency, check result, stall, hand off.
    task automatic convert(input int w, input logic [19:0] b, input int stall);
        int lat;
        int digits;
        int binw;
        int prev;
        digits = (w == 5) ? 5 : 4;
        binw   = (w == 5) ? 17 : 14;
        lat = 0;
        while (rd_ready(w) !== 32'd1 && lat < 20) begin
            tick;
            lat++;
        end
        chk("in_ready_idle", rd_ready(w), 32'd1);
        set_in(w, 1'b1, b);
        set_ordy(w, stall == 0);
        prev = acc_cyc;
        tick;
        acc_cyc = cyc;
        gap     = acc_cyc - prev;
        set_in(w, 1'b0, 20'($urandom));
        lat = 0;
        while (rd_valid(w) !== 32'd1 && lat < 20) begin
            tick;
            lat++;
        end
        chk("latency", lat, digits);
        chk("bin", rd_bin(w), ref_bin(b, digits, binw));
        chk("err", rd_err(w), ref_err(b, digits));
        chk("in_ready_done", rd_ready(w), 32'd0);
        for (int k = 0; k < stall; k++) begin
            tick;
            chk("stall_valid", rd_valid(w), 32'd1);
            chk("stall_bin", rd_bin(w), ref_bin(b, digits, binw));
            chk("stall_in_ready", rd_ready(w), 32'd0);
        end
        set_ordy(w, 1'b1);
        tick;
        chk("valid_drop", rd_valid(w), 32'd0);
        chk("in_ready_back", rd_ready(w), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic [19:0] b;
        int          w;
        rst = 1'b1;
        set_in(4, 1'b0, 20'd0);
        set_in(5, 1'b0, 20'd0);
        set_ordy(4, 1'b0);
        set_ordy(5, 1'b0);
        repeat (3) tick;

        chk("rst_in_ready", rd_ready(4), 32'd0);
        chk("rst_out_valid", rd_valid(4), 32'd0);
        chk("rst_bin", rd_bin(4), 32'd0);
        chk("rst_err", rd_err(4), 32'd0);
        chk("rst_out_valid5", rd_valid(5), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", rd_ready(4), 32'd1);

        convert(4, 20'h00001, 0);
        convert(4, 20'h00123, 0);
        convert(4, 20'h09999, 0);
        convert(4, 20'h00000, 0);
        chk("b2b_gap", gap, 32'd6);

        convert(4, 20'h02531, 3);

        // Reset two cycles into a conversion discards it.
        set_ordy(4, 1'b1);
        set_in(4, 1'b1, 20'h01449);
        tick;
        set_in(4, 1'b0, 20'd0);
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("in_ready_in_rst", rd_ready(4), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("midrst_valid", rd_valid(4), 32'd0);
        chk("midrst_in_ready", rd_ready(4), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("midrst_quiet", rd_valid(4), 32'd0);
        end
        convert(4, 20'h01449, 0);

        // Operand offered together with reset is not taken.
        rst = 1'b1;
        set_in(4, 1'b1, 20'h00007);
        tick;
        rst = 1'b0;
        set_in(4, 1'b0, 20'd0);
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("rst_accept_quiet", rd_valid(4), 32'd0);
        end

        // Reset while a result is waiting in DONE.
        set_ordy(4, 1'b0);
        set_in(4, 1'b1, 20'h00042);
        tick;
        set_in(4, 1'b0, 20'd0);
        repeat (5) tick;
        chk("done_valid", rd_valid(4), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("donerst_valid", rd_valid(4), 32'd0);
        chk("donerst_bin", rd_bin(4), 32'd0);

        convert(4, 20'h012A4, 0);
        chk("bin_12A4", rd_bin(4), 32'd1304);
        convert(4, 20'h01234, 1);
        convert(4, 20'h0FFFF, 0);
        convert(5, 20'h12345, 0);
        chk("bin_12345", rd_bin(5), 32'd12345);
        convert(5, 20'h99999, 2);

        for (int n = 0; n < 24; n++) begin
            w = ($urandom_range(0, 3) == 0) ? 5 : 4;
            b = '0;
            for (int d = 0; d < 5; d++) begin
                b = b << 4;
                if ($urandom_range(0, 7) == 0) b[3:0] = 4'($urandom_range(10, 15));
                else                           b[3:0] = 4'($urandom_range(0, 9));
            end
            if (w == 4) b[19:16] = 4'd0;
            convert(w, b, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
